// File: rtl/nes_controller_reader_pkg.sv
// Shared definitions for the NES pad reader and the processor-side button decode.
package nes_controller_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_LOW   = 2'd2,
    ST_HIGH  = 2'd3
  } state_e;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;
  localparam int unsigned NUM_BTNS   = 8;

  // Phase counter must hold the longest phase: the idle gap or the full latch pulse.
  function automatic int unsigned cnt_width(input int unsigned poll_cyc,
                                            input int unsigned latch_cyc);
    return $clog2((poll_cyc > latch_cyc) ? poll_cyc : latch_cyc);
  endfunction

endpackage

// File: rtl/nes_controller_reader_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, with selectable reset level.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nes_controller_reader.sv
// Polls an NES serial pad (latch, 7 pulses, 8 samples) and presents the buttons as a byte.
module nes_controller_reader
  import nes_controller_reader_pkg::*;
#(
  parameter int unsigned POLL_CYC = 833333,
  parameter int unsigned HALF_CYC = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_pulse,
  output logic [7:0] controller,
  output logic       valid
);

  localparam int unsigned CW = cnt_width(POLL_CYC, 2 * HALF_CYC);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
  localparam logic [2:0]    K_LAST     = 3'(NUM_BTNS - 1);

  logic sync_data;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (ctrl_data),
    .q     (sync_data)
  );

  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [2:0]    k_d, k_q;
  logic [7:0]    shift_d, shift_q;
  logic [7:0]    ctrl_d, ctrl_q;
  logic          valid_d, valid_q;
  logic          latch_d, latch_q;
  logic          pulse_d, pulse_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    k_d     = k_q;
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cnt_q == POLL_LAST) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end
      end
      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      ST_LOW: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d          = '0;
          shift_d[k_q]   = ~sync_data;
          if (k_q == K_LAST) begin
            // Final bit bypasses shift_q so the whole byte lands in one edge.
            ctrl_d            = shift_q;
            ctrl_d[BTN_RIGHT] = ~sync_data;
            valid_d           = 1'b1;
            k_d               = '0;
            state_d           = ST_IDLE;
          end else begin
            state_d = ST_HIGH;
          end
        end
      end
      ST_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          k_d     = k_q + 3'd1;
          state_d = ST_LOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes follow the next state so they are registered yet aligned with it.
    latch_d = (state_d == ST_LATCH);
    pulse_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      shift_q <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      shift_q <= shift_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      latch_q <= latch_d;
      pulse_q <= pulse_d;
    end
  end

  assign ctrl_latch = latch_q;
  assign ctrl_pulse = pulse_q;
  assign controller = ctrl_q;
  assign valid      = valid_q;

endmodule
